// File: rtl/ocra1_rx.sv
// ocra1_rx: OCRA1 four-channel DAC SPI receiver holding per-channel input, control and output registers
module ocra1_rx #(
  parameter int FRAME_BITS = 24,
  parameter int CODE_BITS = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic oc1_clk_i,
  input  logic oc1_syncn_i,
  input  logic oc1_ldacn_i,
  input  logic oc1_sdox_i,
  input  logic oc1_sdoy_i,
  input  logic oc1_sdoz_i,
  input  logic oc1_sdoz2_i,
  output logic [CODE_BITS-1:0] voutx_o,
  output logic [CODE_BITS-1:0] vouty_o,
  output logic [CODE_BITS-1:0] voutz_o,
  output logic [CODE_BITS-1:0] voutz2_o,
  output logic [FRAME_BITS-5:0] ctrlx_o,
  output logic [FRAME_BITS-5:0] ctrly_o,
  output logic [FRAME_BITS-5:0] ctrlz_o,
  output logic [FRAME_BITS-5:0] ctrlz2_o,
  output logic frame_o,
  output logic update_o,
  output logic frame_err_o
);
  logic [6:0] s1;
  logic [2:0] s2;
  logic [4:0] cnt, cnt_base, cnt_nxt;
  logic sclk_fall, sync_fall, sync_rise, ldac_fall, shift, valid;
  logic [FRAME_BITS-1:0] sh [4];
  logic [CODE_BITS-1:0] inr [4], in_nxt [4], outr [4];
  logic [FRAME_BITS-5:0] ctl [4];
  assign sclk_fall = s2[0] & ~s1[4];
  assign sync_fall = s2[1] & ~s1[5];
  assign sync_rise = ~s2[1] & s1[5];
  assign ldac_fall = s2[2] & ~s1[6];
  assign shift = sclk_fall & ~s1[5];
  assign valid = sync_rise && cnt == 5'(FRAME_BITS);
  // a SYNCn fall clears first so a coincident SCLK fall counts as bit one
  assign cnt_base = sync_fall ? 5'd0 : cnt;
  assign cnt_nxt = !shift ? cnt_base : cnt_base == 5'(FRAME_BITS + 1) ? cnt_base : cnt_base + 5'd1;
  always_comb
    for (int c = 0; c < 4; c++)
      in_nxt[c] = (valid && sh[c][FRAME_BITS-1:FRAME_BITS-4] == 4'b0001) ? sh[c][CODE_BITS+1:2] : inr[c];
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 7'b1100000;
      s2 <= 3'b110;
      cnt <= '0;
      frame_o <= 1'b0;
      update_o <= 1'b0;
      frame_err_o <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        sh[c] <= '0;
        inr[c] <= '0;
        outr[c] <= '0;
        ctl[c] <= '0;
      end
    end else begin
      s1 <= {oc1_ldacn_i, oc1_syncn_i, oc1_clk_i, oc1_sdoz2_i, oc1_sdoz_i, oc1_sdoy_i, oc1_sdox_i};
      s2 <= s1[6:4];
      cnt <= cnt_nxt;
      frame_o <= valid;
      update_o <= ldac_fall;
      frame_err_o <= sync_rise & ~valid;
      for (int c = 0; c < 4; c++) begin
        if (shift) sh[c] <= {sh[c][FRAME_BITS-2:0], s1[c]};
        inr[c] <= in_nxt[c];
        if (valid && sh[c][FRAME_BITS-1:FRAME_BITS-4] == 4'b0010) ctl[c] <= sh[c][FRAME_BITS-5:0];
        if (ldac_fall) outr[c] <= in_nxt[c];
      end
    end
  end
  assign voutx_o = outr[0];
  assign vouty_o = outr[1];
  assign voutz_o = outr[2];
  assign voutz2_o = outr[3];
  assign ctrlx_o = ctl[0];
  assign ctrly_o = ctl[1];
  assign ctrlz_o = ctl[2];
  assign ctrlz2_o = ctl[3];
endmodule

// File: tb/tb_ocra1_rx.sv
// tb_ocra1_rx: randomized and directed bench for ocra1_rx against a frame-level register model
module tb_ocra1_rx;
  logic clk = 0, rst = 1, sclk = 0, syncn = 1, ldacn = 1;
  logic [3:0] sdo = '0;
  logic [17:0] voutx, vouty, voutz, voutz2;
  logic [19:0] ctrlx, ctrly, ctrlz, ctrlz2;
  logic frame, update, frame_err;
  int cyc = 0, total = 0, bad = 0;
  int fr_at = -1, err_at = -1, upd_at = -1, rst_at = -1;
  logic [23:0] tx_w [4], pend [4];
  logic [17:0] m_in [4], m_out [4], dv [4];
  logic [19:0] m_ctrl [4], dc [4];

  ocra1_rx dut (
    .clk(clk), .rst(rst), .oc1_clk_i(sclk), .oc1_syncn_i(syncn), .oc1_ldacn_i(ldacn),
    .oc1_sdox_i(sdo[0]), .oc1_sdoy_i(sdo[1]), .oc1_sdoz_i(sdo[2]), .oc1_sdoz2_i(sdo[3]),
    .voutx_o(voutx), .vouty_o(vouty), .voutz_o(voutz), .voutz2_o(voutz2),
    .ctrlx_o(ctrlx), .ctrly_o(ctrly), .ctrlz_o(ctrlz), .ctrlz2_o(ctrlz2),
    .frame_o(frame), .update_o(update), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // model: register effects land two clk edges after the driving negedge
  always @(negedge clk) if (cyc > 0) begin
    if (rst_at == cyc)
      for (int c = 0; c < 4; c++) begin
        m_in[c] = '0;
        m_out[c] = '0;
        m_ctrl[c] = '0;
      end
    if (fr_at == cyc)
      for (int c = 0; c < 4; c++)
        if (pend[c][23:20] == 4'b0001) m_in[c] = pend[c][19:2];
        else if (pend[c][23:20] == 4'b0010) m_ctrl[c] = pend[c][19:0];
    if (upd_at == cyc) m_out = m_in;
    dv = '{voutx, vouty, voutz, voutz2};
    dc = '{ctrlx, ctrly, ctrlz, ctrlz2};
    chk("frame_o", 32'(frame), 32'(fr_at == cyc));
    chk("frame_err_o", 32'(frame_err), 32'(err_at == cyc));
    chk("update_o", 32'(update), 32'(upd_at == cyc));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("vout%0d", c), 32'(dv[c]), 32'(m_out[c]));
      chk($sformatf("ctrl%0d", c), 32'(dc[c]), 32'(m_ctrl[c]));
    end
  end

  task automatic send_bits(input int from, input int n, input int div);
    for (int i = from; i < from + n; i++) begin
      @(negedge clk);
      sclk = 1;
      for (int c = 0; c < 4; c++) sdo[c] = i < 24 ? tx_w[c][23-i] : 1'($urandom);
      repeat (div - 1) @(negedge clk);
      @(negedge clk);
      sclk = 0;
      repeat (div - 1) @(negedge clk);
    end
  endtask

  task automatic open_frame(input int div);
    @(negedge clk);
    syncn = 0;
    repeat (div) @(negedge clk);
  endtask

  task automatic close_frame(input int nb, input bit coinc);
    @(negedge clk);
    syncn = 1;
    if (nb == 24) begin
      pend = tx_w;
      fr_at = cyc + 2;
    end else err_at = cyc + 2;
    if (coinc) begin
      ldacn = 0;
      upd_at = cyc + 2;
    end
    repeat (3) @(negedge clk);
    ldacn = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_tx(input int nb, input int div, input bit coinc);
    open_frame(div);
    send_bits(0, nb, div);
    close_frame(nb, coinc);
  endtask

  task automatic ldac;
    @(negedge clk);
    ldacn = 0;
    upd_at = cyc + 2;
    repeat (4) @(negedge clk);
    ldacn = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_all(input logic [23:0] a, b, c, d);
    tx_w = '{a, b, c, d};
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      m_in[c] = '0;
      m_out[c] = '0;
      m_ctrl[c] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_vout", 32'(voutx), 32'h0);
    chk("reset_ctrl", 32'(ctrlz2), 32'h0);
    set_all(24'h200002, 24'h200002, 24'h200002, 24'h200002);
    frame_tx(24, 2, 0);
    chk("lit_ctrlx", 32'(ctrlx), 32'h00002);
    chk("lit_ctrlz2", 32'(ctrlz2), 32'h00002);
    chk("lit_vout_after_ctrl", 32'(vouty), 32'h0);
    set_all(24'h100004, 24'h100008, 24'h10000C, 24'h100010);
    frame_tx(24, 3, 0);
    ldac();
    chk("lit_voutx", 32'(voutx), 32'h1);
    chk("lit_voutz2", 32'(voutz2), 32'h4);
    foreach (tx_w[c]) tx_w[c] = 24'h0;
    for (int k = 0; k < 2; k++) begin
      set_all(24'h1FFFFC, 24'h1FFFF8, 24'h1FFFF4, 24'h1FFFF0);
      frame_tx(24, k == 0 ? 32 : 1, 0);
      ldac();
      chk("lit_neg_x", 32'(voutx), 32'h3FFFF);
      chk("lit_neg_y", 32'(vouty), 32'h3FFFE);
      chk("lit_neg_z2", 32'(voutz2), 32'h3FFFC);
      set_all(24'h100004, 24'h100008, 24'h10000C, 24'h100010);
      frame_tx(24, 3, 0);
      ldac();
    end
    set_all(24'h100028, 24'h100028, 24'h100028, 24'h100028);
    frame_tx(23, 2, 0);
    ldac();
    chk("lit_short_keep", 32'(vouty), 32'h2);
    frame_tx(26, 2, 0);
    ldac();
    chk("lit_long_keep", 32'(voutz), 32'h3);
    set_all(24'h100014, 24'h100014, 24'h100014, 24'h100014);
    frame_tx(24, 2, 1);
    chk("lit_coinc", 32'(voutx), 32'h5);
    set_all(24'h100018, 24'h100018, 24'h100018, 24'h100018);
    open_frame(2);
    send_bits(0, 12, 2);
    @(negedge clk);
    rst = 1;
    rst_at = cyc + 1;
    @(negedge clk);
    rst = 0;
    send_bits(12, 12, 2);
    close_frame(12, 0);
    chk("lit_rst_vout", 32'(voutx), 32'h0);
    frame_tx(24, 2, 0);
    ldac();
    chk("lit_after_rst", 32'(voutz2), 32'h6);
    for (int k = 0; k < 40; k++) begin
      int nb, div;
      for (int c = 0; c < 4; c++) begin
        logic [3:0] hdr;
        case ($urandom_range(0, 4))
          0, 1: hdr = 4'b0001;
          2: hdr = 4'b0010;
          3: hdr = 4'b1001;
          default: hdr = 4'($urandom);
        endcase
        tx_w[c] = {hdr, 20'($urandom)};
      end
      nb = $urandom_range(0, 7) == 0 ? 23 + 3 * $urandom_range(0, 1) : 24;
      div = $urandom_range(1, 6);
      frame_tx(nb, div, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) ldac();
    end
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
